instruction_fetch_unit: RTL and testbench

Fetch stage directly upstream of the IF/ID pipeline register. It holds the PC and issues one outstanding request at a time to the instruction memory over a valid/ready request channel and a valid response channel. It buffers the returned word and presents {pc, pc+4, instr} to IF/ID. It honours the pipeline stall and branch/jump redirect, and produces the bubble signal that drives the IF/ID register's clear.

---
 rtl/instruction_fetch_unit.sv | 115 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage feeding the IF/ID register: one outstanding imem request at a time,
// buffers the returned word and presents {pc, pc+4, instr} with a bubble flag.
module instruction_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            if_bubble
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            kill_q;
  logic [XLEN-1:0] buf_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_pc_plus4_q;
  logic            if_valid_q;

  logic [XLEN-1:0] redir_pc_d;
  logic [XLEN-1:0] inflight_plus4_d;

  // Redirect targets are word aligned; the low two bits are simply dropped.
  assign redir_pc_d       = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign inflight_plus4_d = inflight_pc_q + XLEN'(3'd4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      inflight_pc_q <= {XLEN{1'b0}};
      kill_q        <= 1'b0;
      buf_q         <= {XLEN{1'b0}};
      if_pc_q       <= {XLEN{1'b0}};
      if_pc_plus4_q <= {XLEN{1'b0}};
      if_valid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            inflight_pc_q <= pc_q;
            state_q       <= S_WAIT;
            kill_q        <= redirect_valid;
          end
          if (redirect_valid) begin
            pc_q <= redir_pc_d;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            kill_q <= 1'b0;
            // A response is kept only if no redirect has overtaken it.
            if (!kill_q && !redirect_valid) begin
              buf_q         <= imem_rsp_data;
              if_pc_q       <= inflight_pc_q;
              if_pc_plus4_q <= inflight_plus4_d;
              if_valid_q    <= 1'b1;
              state_q       <= S_HOLD;
            end else begin
              state_q <= S_REQ;
            end
          end else if (redirect_valid) begin
            kill_q <= 1'b1;
          end
          if (redirect_valid) begin
            pc_q <= redir_pc_d;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_q       <= redir_pc_d;
            if_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end else if (!stall) begin
            pc_q       <= if_pc_plus4_q;
            if_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        default: begin
          state_q    <= S_REQ;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = reset && (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign if_valid       = if_valid_q;
  assign if_bubble      = ~if_valid_q;
  assign if_instr       = buf_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc_plus4_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: behavioural memory with configurable latency
// and a scoreboard of expected fetched PCs checked whenever if_valid rises.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_bubble;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mem_lat = 1;
  int due_q[$];
  logic [31:0] data_q[$];
  logic [31:0] exp_q[$];

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_bubble(if_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: samples 1 ns before the edge, responds 1 ns after it.
  initial begin
    logic hs, rs;
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #4;
      hs = imem_req_valid && imem_req_ready;
      rs = reset;
      a  = imem_addr;
      @(posedge clk);
      cyc++;
      if (!rs) begin
        due_q.delete();
        data_q.delete();
      end else if (hs) begin
        due_q.push_back(cyc + mem_lat);
        data_q.push_back(a ^ XORK);
      end
      #1;
      if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every new instruction must match the next expected PC.
  initial begin
    logic pv;
    logic [31:0] e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      n_cmp++;
      if (if_bubble !== ~if_valid) begin
        n_bad++;
        $display("FAIL bubble: if_bubble=%b required %b", if_bubble, ~if_valid);
      end
      if (if_valid === 1'b1 && !pv) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_fetch: if_pc=%h required none", if_pc);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e || if_pc_plus4 !== e + 32'd4 || if_instr !== (e ^ XORK)) begin
            n_bad++;
            $display("FAIL fetch: pc=%h pc4=%h instr=%h required %h %h %h",
                     if_pc, if_pc_plus4, if_instr, e, e + 32'd4, e ^ XORK);
          end
        end
      end
      pv = (if_valid === 1'b1);
    end
  end

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_valid) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_valid: timeout after %0d cycles required if_valid=1", budget);
  endtask

  task automatic wait_hs(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_hs: timeout after %0d cycles required handshake", budget);
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_bubble !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_ctrl: req=%b valid=%b bubble=%b required 0 0 1",
                 imem_req_valid, if_valid, if_bubble);
      end
      n_cmp++;
      if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0 || if_instr !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_data: pc=%h pc4=%h instr=%h required 0 0 0",
                 if_pc, if_pc_plus4, if_instr);
      end
    end
  endtask

  task automatic test_basic_fetch();
    int rise[3];
    int n;
    logic pv;
    n = 0; pv = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    reset = 1'b1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_addr == 32'h8) stall = 1'b1;
      if (if_valid && !pv) begin
        rise[n] = cyc;
        n++;
      end
      pv = if_valid;
    end
    n_cmp++;
    if (n != 3) begin
      n_bad++;
      $display("FAIL basic_count: fetched %0d required 3", n);
    end else begin
      n_cmp++;
      if (rise[1] - rise[0] != 3 || rise[2] - rise[1] != 3) begin
        n_bad++;
        $display("FAIL basic_period: gaps %0d %0d required 3 3",
                 rise[1] - rise[0], rise[2] - rise[1]);
      end
    end
  endtask

  task automatic test_stall();
    exp_q.push_back(32'hC);
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== (32'h8 ^ XORK) ||
          imem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold: valid=%b pc=%h instr=%h req=%b required 1 8 %h 0",
                 if_valid, if_pc, if_instr, imem_req_valid, 32'h8 ^ XORK);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin
      n_bad++;
      $display("FAIL stall_next: req=%b addr=%h required 1 0000000c", imem_req_valid, imem_addr);
    end
    stall = 1'b1;
    wait_valid(10);
  endtask

  task automatic test_ready_low();
    int i;
    reset = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    reset = 1'b1;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_addr == 32'h4) break;
    end
    imem_req_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin
        n_bad++;
        $display("FAIL ready_low: req=%b addr=%h required 1 00000004", imem_req_valid, imem_addr);
      end
    end
    imem_req_ready = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_hs: req=%b required 0", imem_req_valid);
    end
    wait_valid(10);
  endtask

  task automatic test_redirect_wait();
    mem_lat = 2;
    exp_q.push_back(32'h100);
    stall = 1'b0;
    wait_hs(10);
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_wait_state: req=%b required 0", imem_req_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) break;
      @(negedge clk);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL redir_wait_addr: req=%b addr=%h required 1 00000100", imem_req_valid, imem_addr);
    end
    wait_valid(15);
    mem_lat = 1;
  endtask

  task automatic test_redirect_rsp();
    exp_q.push_back(32'h200);
    stall = 1'b0;
    wait_hs(10);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL redir_rsp: req=%b addr=%h required 1 00000200", imem_req_valid, imem_addr);
    end
    wait_valid(10);
  endtask

  task automatic test_redirect_handshake();
    exp_q.push_back(32'h300);
    stall = 1'b0;
    wait_hs(10);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_hs_wait: req=%b required 0", imem_req_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin
      n_bad++;
      $display("FAIL redir_hs_addr: req=%b addr=%h required 1 00000300", imem_req_valid, imem_addr);
    end
    wait_valid(10);
  endtask

  task automatic test_wrap();
    exp_q.push_back(32'hFFFF_FFFC);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL redir_hold: valid=%b addr=%h required 0 fffffffc", if_valid, imem_addr);
    end
    wait_valid(10);
    n_cmp++;
    if (if_pc_plus4 !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_plus4: if_pc_plus4=%h required 00000000", if_pc_plus4);
    end
    exp_q.push_back(32'h0);
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_addr: req=%b addr=%h required 1 00000000", imem_req_valid, imem_addr);
    end
    wait_valid(10);
  endtask

  task automatic test_reset_mid_wait();
    mem_lat = 2;
    exp_q.push_back(32'h0);
    stall = 1'b0;
    wait_hs(10);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid: req=%b valid=%b required 0 0", imem_req_valid, if_valid);
      end
      @(negedge clk);
    end
    reset = 1'b1; stall = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_first_req: req=%b addr=%h required 1 00000000", imem_req_valid, imem_addr);
    end
    wait_valid(15);
    mem_lat = 1;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_ready_low();
    test_redirect_wait();
    test_redirect_rsp();
    test_redirect_handshake();
    test_wrap();
    test_reset_mid_wait();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
